alu_accum: RTL

Parametrised, registered successor to the datapath ALU. Performs ADD/XOR/MIN in one cycle. MINALL becomes a true multi-beat reduction: the minimum over a stream of operand pairs, terminated by a `last` flag. Valid/ready handshakes sit on the input and output sides, so the block slots between the register-file read stage and the write-back stage of the processor.

---
 rtl/alu_accum.sv | 138 +++++++++++++
 1 files changed

// File: rtl/alu_accum.sv
// Registered ADD/XOR/MIN ALU with a multi-beat MINALL reduction and valid/ready on both sides.
// Optional: define ALU_SAT_EN to make ADD saturate to all-ones on carry-out.
module alu_accum #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ins,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             carry,
  output logic             zero,
  output logic [CNT_W-1:0] count,
  output logic             err
);
  localparam logic [3:0] OP_ADD    = 4'b0010;
  localparam logic [3:0] OP_XOR    = 4'b0011;
  localparam logic [3:0] OP_MIN    = 4'b0100;
  localparam logic [3:0] OP_MINALL = 4'b0111;

  typedef enum logic {IDLE, ACC} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             accept;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] min_ab, min_run;
  logic [CNT_W-1:0] cnt_base, cnt_run;
  logic [CNT_W:0]   cnt_ext;

  logic             ld;
  logic [WIDTH-1:0] res;
  logic             res_c;
  logic [CNT_W-1:0] res_cnt;
  logic             err_d;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  assign sum    = {1'b0, a_in} + {1'b0, b_in};
  assign min_ab = (b_in < a_in) ? b_in : a_in;

  // In IDLE the running min/count start fresh, so one path covers both FSM states.
  assign min_run  = (state_q == ACC && acc_q < min_ab) ? acc_q : min_ab;
  assign cnt_base = (state_q == ACC) ? cnt_q : '0;
  assign cnt_ext  = {1'b0, cnt_base} + (CNT_W+1)'(2);
  assign cnt_run  = cnt_ext[CNT_W] ? '1 : cnt_ext[CNT_W-1:0];

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ld      = 1'b0;
    res     = '0;
    res_c   = 1'b0;
    res_cnt = '0;
    err_d   = 1'b0;
    if (accept) begin
      case (ins)
        OP_ADD: begin
          ld    = 1'b1;
          res_c = sum[WIDTH];
`ifdef ALU_SAT_EN
          res   = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
`else
          res   = sum[WIDTH-1:0];
`endif
        end
        OP_XOR: begin
          ld  = 1'b1;
          res = a_in ^ b_in;
        end
        OP_MIN: begin
          ld  = 1'b1;
          res = min_ab;
        end
        OP_MINALL: begin
          if (last) begin
            ld      = 1'b1;
            res     = min_run;
            res_cnt = cnt_run;
            state_d = IDLE;
          end else begin
            acc_d   = min_run;
            cnt_d   = cnt_run;
            state_d = ACC;
          end
        end
        default: begin
          ld    = 1'b1;
          err_d = 1'b1;
        end
      endcase
      // Any non-MINALL beat in ACC abandons the reduction; err is a single pulse either way.
      if (state_q == ACC && ins != OP_MINALL) begin
        err_d   = 1'b1;
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      out_valid <= 1'b0;
      alu_out   <= '0;
      carry     <= 1'b0;
      zero      <= 1'b0;
      count     <= '0;
      err       <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      err     <= err_d;
      if (ld) begin
        out_valid <= 1'b1;
        alu_out   <= res;
        carry     <= res_c;
        zero      <= (res == '0);
        count     <= res_cnt;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule
